// File: rtl/fcl_pkg.sv
// ---------------------------------------------------------------------------
// fcl_pkg
// Shared definitions for the fully-connected-layer MAC accumulator:
//   - default width constants used as parameter defaults
//   - fcl_state_e : frame controller states (IDLE / ACCUM / DONE)
//   - fcl_sat_add : signed add clamped to a given bit width, used by the
//                   lanes when the FCL_SAT_EN macro is defined
// No ports (package).
// ---------------------------------------------------------------------------
package fcl_pkg;

  localparam int FCL_DATA_WIDTH   = 8;
  localparam int FCL_WEIGHT_WIDTH = 8;
  localparam int FCL_ACC_WIDTH    = 22;
  localparam int FCL_NUM_NEURONS  = 4;
  localparam int FCL_NUM_TERMS    = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } fcl_state_e;

  // Operands arrive sign-extended to 64 bits, so the 64-bit sum cannot
  // overflow for any width below 63; the result is then clamped to the
  // signed range of 'width' bits and returned sign-extended.
  function automatic logic signed [63:0] fcl_sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        width
  );
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fcl_mac_lane.sv
// ---------------------------------------------------------------------------
// fcl_mac_lane
// One neuron lane: signed multiply of the shared activation by this lane's
// weight, sign-extension of the full-precision product to the accumulator
// width, then either a bias load (first beat of a frame) or an accumulate.
// Optional macro FCL_SAT_EN: when defined every add saturates to the signed
// ACC_WIDTH limits, otherwise adds wrap in two's complement.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears accumulator)
//   load      : this beat starts a frame, so bias replaces the accumulator
//   en        : beat accepted, update accumulator
//   data      : signed activation
//   weight    : signed weight for this lane
//   bias      : signed bias, only used when load is high
//   sum       : value the accumulator takes if this beat is accepted
// ---------------------------------------------------------------------------
module fcl_mac_lane
  import fcl_pkg::*;
#(
  parameter int DATA_WIDTH   = FCL_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = FCL_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = FCL_ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   data,
  input  logic signed [WEIGHT_WIDTH-1:0] weight,
  input  logic signed [ACC_WIDTH-1:0]    bias,
  output logic signed [ACC_WIDTH-1:0]    sum
);

  logic signed [DATA_WIDTH+WEIGHT_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]               prod_ext;
  logic signed [ACC_WIDTH-1:0]               base;
  logic signed [ACC_WIDTH-1:0]               acc;

  assign prod     = data * weight;
  // Size cast of a signed value sign-extends.
  assign prod_ext = ACC_WIDTH'(prod);
  assign base     = load ? bias : acc;

`ifdef FCL_SAT_EN
  logic signed [63:0] sat_sum;
  assign sat_sum = fcl_sat_add(64'(base), 64'(prod_ext), ACC_WIDTH);
  assign sum     = sat_sum[ACC_WIDTH-1:0];
`else
  assign sum = base + prod_ext;
`endif

  // Accumulator register: only moves on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fcl_mac_accum.sv
// ---------------------------------------------------------------------------
// fcl_mac_accum
// Fully-connected-layer MAC: NUM_NEURONS lanes share one activation stream.
// Each frame is NUM_TERMS accepted beats; the first beat loads bias plus
// product, later beats accumulate. After the last beat the lane sums are
// captured into out_data_o and offered with out_valid_o until taken.
// Optional macro FCL_SAT_EN: saturating accumulation (default: wrapping).
// Ports:
//   fcl_clk, fcl_rst        : clock, synchronous active-high reset
//   in_valid_i, in_ready_o  : input beat handshake (ready low while DONE)
//   in_data_i               : signed activation shared by all lanes
//   wt_i                    : packed signed per-lane weights
//   bias_i                  : packed signed per-lane biases (first beat only)
//   out_valid_o, out_ready_i: result handshake
//   out_data_o              : packed signed neuron sums
// ---------------------------------------------------------------------------
module fcl_mac_accum
  import fcl_pkg::*;
#(
  parameter int DATA_WIDTH   = FCL_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = FCL_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = FCL_ACC_WIDTH,
  parameter int NUM_NEURONS  = FCL_NUM_NEURONS,
  parameter int NUM_TERMS    = FCL_NUM_TERMS
) (
  input  logic                                fcl_clk,
  input  logic                                fcl_rst,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [DATA_WIDTH-1:0]               in_data_i,
  input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] wt_i,
  input  logic [NUM_NEURONS*ACC_WIDTH-1:0]    bias_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [NUM_NEURONS*ACC_WIDTH-1:0]    out_data_o
);

  localparam int               CNT_W    = $clog2(NUM_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  fcl_state_e                       state;
  fcl_state_e                       state_next;
  logic [CNT_W-1:0]                 count;
  logic                             accept;
  logic                             first_beat;
  logic                             last_beat;
  logic [NUM_NEURONS*ACC_WIDTH-1:0] lane_sum;

  assign accept     = in_valid_i && in_ready_o;
  // In IDLE the counter is always zero, so IDLE means "next beat is first".
  assign first_beat = (state == ST_IDLE);
  assign last_beat  = (count == LAST_CNT);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    fcl_mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
      .clk   (fcl_clk),
      .rst   (fcl_rst),
      .load  (first_beat),
      .en    (accept),
      .data  (in_data_i),
      .weight(wt_i[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .bias  (bias_i[n*ACC_WIDTH +: ACC_WIDTH]),
      .sum   (lane_sum[n*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  // State register for the frame controller.
  always_ff @(posedge fcl_clk) begin
    if (fcl_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. in_valid_i is used directly in the
  // states where ready is high so the block never depends on its own output.
  always_comb begin
    state_next  = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_next = (NUM_TERMS == 1) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat counter: counts accepted beats, cleared when the result is taken.
  // It peaks at NUM_TERMS while in DONE, which always fits in CNT_W bits.
  always_ff @(posedge fcl_clk) begin
    if (fcl_rst) begin
      count <= '0;
    end else if ((state == ST_DONE) && out_ready_i) begin
      count <= '0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
    end
  end

  // Result register: captures the lane sums on the last beat so the output
  // stays put while the accumulators start the next frame.
  always_ff @(posedge fcl_clk) begin
    if (fcl_rst) begin
      out_data_o <= '0;
    end else if (accept && last_beat) begin
      out_data_o <= lane_sum;
    end
  end

endmodule

// File: tb/tb_fcl_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_fcl_mac_accum
// Three DUT copies (NUM_TERMS = 3, 2, 1) share one stimulus stream. A
// frame-level model per copy predicts every output each cycle; directed
// frames with hand-computed sums pin the model, then random traffic runs.
// Honours FCL_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fcl_mac_accum;

  localparam int DW  = 8;
  localparam int WW  = 8;
  localparam int ACC = 22;
  localparam int NN  = 4;
  localparam int NI  = 3;

`ifdef FCL_SAT_EN
  localparam longint EXP_SAT_CASE = 64'h1FFFFF;
`else
  localparam longint EXP_SAT_CASE = 64'h203E02;
`endif

  logic              fcl_clk = 1'b0;
  logic              fcl_rst;
  logic              in_valid;
  logic              out_ready;
  logic [DW-1:0]     in_data;
  logic [NN*WW-1:0]  wt;
  logic [NN*ACC-1:0] bias;
  logic              in_ready  [NI];
  logic              out_valid [NI];
  logic [NN*ACC-1:0] out_data  [NI];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per DUT copy.
  bit     m_known = 1'b0;
  bit     m_pend  [NI];
  int     m_count [NI];
  longint m_acc   [NI][NN];
  longint m_out   [NI][NN];

  always #5 fcl_clk = ~fcl_clk;

  // Copy g runs frames of 3-g beats.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    fcl_mac_accum #(
      .DATA_WIDTH  (DW),
      .WEIGHT_WIDTH(WW),
      .ACC_WIDTH   (ACC),
      .NUM_NEURONS (NN),
      .NUM_TERMS   (3 - g)
    ) u_dut (
      .fcl_clk    (fcl_clk),
      .fcl_rst    (fcl_rst),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready[g]),
      .in_data_i  (in_data),
      .wt_i       (wt),
      .bias_i     (bias),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready),
      .out_data_o (out_data[g])
    );
  end

  function automatic logic [NN*WW-1:0] allWt(input int w);
    logic [NN*WW-1:0] r;
    for (int n = 0; n < NN; n++) r[n*WW +: WW] = WW'(w);
    return r;
  endfunction

  function automatic logic [NN*ACC-1:0] allBias(input int b);
    logic [NN*ACC-1:0] r;
    for (int n = 0; n < NN; n++) r[n*ACC +: ACC] = ACC'(b);
    return r;
  endfunction

  // Accumulator arithmetic on plain integers: clamp or wrap to ACC bits.
  function automatic longint addAcc(input longint a, input longint b);
    longint s;
    longint lim;
    s   = a + b;
    lim = longint'(1) << (ACC - 1);
`ifdef FCL_SAT_EN
    if (s > lim - 1) s = lim - 1;
    else if (s < -lim) s = -lim;
`else
    s = s & ((lim << 1) - 1);
    if (s >= lim) s = s - (lim << 1);
`endif
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, and return
  // just after that edge.
  task automatic applyStimulus(input logic rst, input logic v, input int d,
                               input logic [NN*WW-1:0] w, input logic [NN*ACC-1:0] b,
                               input logic rdy);
    fcl_rst   = rst;
    in_valid  = v;
    in_data   = DW'(d);
    wt        = w;
    bias      = b;
    out_ready = rdy;
    @(posedge fcl_clk);
    #1;
  endtask

  // Compare every output of every copy against the model, then advance the
  // model by what the coming rising edge will do with the current inputs.
  always @(negedge fcl_clk) begin
    if (m_known) begin
      for (int g = 0; g < NI; g++) begin
        checkOutput($sformatf("dut%0d out_valid", g), longint'(out_valid[g]), longint'(m_pend[g]));
        checkOutput($sformatf("dut%0d in_ready", g), longint'(in_ready[g]), longint'(!m_pend[g]));
        for (int n = 0; n < NN; n++) begin
          checkOutput($sformatf("dut%0d lane%0d out_data", g, n),
                      longint'($signed(out_data[g][n*ACC +: ACC])), m_out[g][n]);
        end
      end
    end
    if (fcl_rst) begin
      m_known = 1'b1;
      for (int g = 0; g < NI; g++) begin
        m_pend[g]  = 1'b0;
        m_count[g] = 0;
        for (int n = 0; n < NN; n++) begin
          m_acc[g][n] = 0;
          m_out[g][n] = 0;
        end
      end
    end else if (m_known) begin
      for (int g = 0; g < NI; g++) begin
        if (m_pend[g]) begin
          if (out_ready) m_pend[g] = 1'b0;
        end else if (in_valid) begin
          for (int n = 0; n < NN; n++) begin
            longint prod;
            longint start;
            prod  = longint'($signed(in_data)) * longint'($signed(wt[n*WW +: WW]));
            start = (m_count[g] == 0) ? longint'($signed(bias[n*ACC +: ACC])) : m_acc[g][n];
            m_acc[g][n] = addAcc(start, prod);
          end
          m_count[g]++;
          if (m_count[g] == 3 - g) begin
            for (int n = 0; n < NN; n++) m_out[g][n] = m_acc[g][n];
            m_pend[g]  = 1'b1;
            m_count[g] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [NN*ACC-1:0] b29;
    logic [NN*WW-1:0]  rw;
    logic [NN*ACC-1:0] rb;

    fcl_rst = 1'b1; in_valid = 1'b0; in_data = '0; wt = '0; bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge fcl_clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checkOutput($sformatf("reset dut%0d out_valid", g), longint'(out_valid[g]), 0);
      checkOutput($sformatf("reset dut%0d in_ready", g), longint'(in_ready[g]), 1);
      checkOutput($sformatf("reset dut%0d out_data", g), longint'(out_data[g][ACC-1:0]), 0);
    end

    // Three-beat frame, bias 0, data 1,2,3, weights 1: every lane 6.
    applyStimulus(1'b0, 1'b1, 1, allWt(1), allBias(0), 1'b0);
    applyStimulus(1'b0, 1'b1, 2, allWt(1), allBias(0), 1'b0);
    checkOutput("t3 valid before last beat", longint'(out_valid[0]), 0);
    applyStimulus(1'b0, 1'b1, 3, allWt(1), allBias(0), 1'b0);
    checkOutput("t3 valid after last beat", longint'(out_valid[0]), 1);
    for (int n = 0; n < NN; n++)
      checkOutput($sformatf("t3 lane%0d sum", n), longint'($signed(out_data[0][n*ACC +: ACC])), 6);

    // Back-pressure: beats offered while DONE must be ignored.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b1, 9, allWt(9), allBias(5), 1'b0);
      checkOutput("stall valid", longint'(out_valid[0]), 1);
      checkOutput("stall in_ready", longint'(in_ready[0]), 0);
      checkOutput("stall lane3", longint'($signed(out_data[0][3*ACC +: ACC])), 6);
    end
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);
    checkOutput("release valid", longint'(out_valid[0]), 0);
    checkOutput("release in_ready", longint'(in_ready[0]), 1);
    applyStimulus(1'b0, 1'b1, 2, allWt(3), allBias(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 2, allWt(3), allBias(1), 1'b0);
    applyStimulus(1'b0, 1'b1, 2, allWt(3), allBias(1), 1'b0);
    checkOutput("after stall sum", longint'($signed(out_data[0][ACC-1:0])), 19);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    // Reset after two of three beats discards the partial frame.
    applyStimulus(1'b0, 1'b1, 50, allWt(1), allBias(0), 1'b0);
    applyStimulus(1'b0, 1'b1, 50, allWt(1), allBias(0), 1'b0);
    applyStimulus(1'b1, 1'b0, 0, allWt(0), allBias(0), 1'b0);
    checkOutput("midframe reset valid", longint'(out_valid[0]), 0);
    applyStimulus(1'b0, 1'b1, 1, allWt(2), allBias(0), 1'b0);
    applyStimulus(1'b0, 1'b1, 2, allWt(2), allBias(0), 1'b0);
    checkOutput("post reset valid early", longint'(out_valid[0]), 0);
    applyStimulus(1'b0, 1'b1, 3, allWt(2), allBias(0), 1'b0);
    checkOutput("post reset valid", longint'(out_valid[0]), 1);
    checkOutput("post reset sum", longint'($signed(out_data[0][ACC-1:0])), 12);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    // Two-beat frame with negative result: lane0 -15, lane1 -5.
    b29 = '0;
    b29[ACC-1:0] = ACC'(-10);
    applyStimulus(1'b1, 1'b0, 0, allWt(0), allBias(0), 1'b0);
    applyStimulus(1'b0, 1'b1, 3, allWt(5), b29, 1'b0);
    applyStimulus(1'b0, 1'b1, -4, allWt(5), b29, 1'b0);
    checkOutput("t2 valid", longint'(out_valid[1]), 1);
    checkOutput("t2 lane0 bits", longint'(out_data[1][ACC-1:0]), 64'h3FFFF1);
    checkOutput("t2 lane1 bits", longint'(out_data[1][2*ACC-1:ACC]), 64'h3FFFFB);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    // Overflow past the positive limit: saturates or wraps.
    applyStimulus(1'b1, 1'b0, 0, allWt(0), allBias(0), 1'b0);
    applyStimulus(1'b0, 1'b1, 127, allWt(127), allBias(32'h1FFF00), 1'b0);
    applyStimulus(1'b0, 1'b1, 1, allWt(1), allBias(32'h1FFF00), 1'b0);
    checkOutput("overflow lane0 bits", longint'(out_data[1][ACC-1:0]), EXP_SAT_CASE);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    // Single-beat frame: 7 + 2*(-3) = 1.
    applyStimulus(1'b1, 1'b0, 0, allWt(0), allBias(0), 1'b0);
    checkOutput("t1 valid idle", longint'(out_valid[2]), 0);
    applyStimulus(1'b0, 1'b1, 2, allWt(-3), allBias(7), 1'b0);
    checkOutput("t1 valid", longint'(out_valid[2]), 1);
    for (int n = 0; n < NN; n++)
      checkOutput($sformatf("t1 lane%0d sum", n), longint'($signed(out_data[2][n*ACC +: ACC])), 1);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < NN; n++) begin
        rw[n*WW +: WW]   = WW'($urandom);
        rb[n*ACC +: ACC] = ACC'($urandom);
      end
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    int'($urandom), rw, rb, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);
    applyStimulus(1'b0, 1'b0, 0, allWt(0), allBias(0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fcl_mac_accum.md
FCL_MAC_ACCUM -- requirements
Module: fcl_mac_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed input activation width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: signed weight width.
REQ-003 SHALL have parameter ACC_WIDTH, default 22: signed accumulator/output width (equals ReLU INPUT_WIDTH).
REQ-004 SHALL have parameter NUM_NEURONS, default 4: parallel neuron lanes (equals ReLU NUM_INPUTS).
REQ-005 SHALL have parameter NUM_TERMS, default 120: input beats per frame, legal range 1..1023.
REQ-006 SHALL have port fcl_clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port fcl_rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): input beat handshake.
REQ-009 SHALL have port in_data_i, input, DATA_WIDTH: signed activation, shared by all lanes.
REQ-010 SHALL have port wt_i, input, NUM_NEURONS x WEIGHT_WIDTH packed: signed per-lane weight for the current beat.
REQ-011 SHALL have port bias_i, input, NUM_NEURONS x ACC_WIDTH packed: signed per-lane bias.
REQ-012 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): result handshake.
REQ-013 SHALL have port out_data_o, output, NUM_NEURONS x ACC_WIDTH packed: signed neuron sums, driving actv_in_i of the ReLU stage.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid_i and in_ready_o are both 1.
REQ-015 FSM states SHALL be IDLE, ACCUM and DONE; IDLE->ACCUM on an accepted beat when NUM_TERMS>1; ACCUM->DONE on the accepted beat bringing the count to NUM_TERMS; IDLE->DONE directly when NUM_TERMS==1; DONE->IDLE on out_valid_o and out_ready_i both 1.
REQ-016 in_ready_o SHALL be 1 in IDLE and ACCUM and 0 in DONE; there is no same-cycle bypass from output handshake to input acceptance.
REQ-017 On the first beat of a frame, each lane SHALL load bias_i[n] + sext(in_data_i*wt_i[n]); bias_i SHALL be sampled only on that beat.
REQ-018 On subsequent beats, each lane SHALL add sext(in_data_i*wt_i[n]) to its accumulator; the product is a full-precision signed DATA_WIDTH+WEIGHT_WIDTH value sign-extended to ACC_WIDTH.
REQ-019 The beat counter SHALL be $clog2(NUM_TERMS+1) bits wide, clear to 0 on entry to IDLE, and never wrap within a frame.
REQ-020 out_valid_o SHALL assert on the cycle after the last beat is accepted (latency 1), and SHALL hold with out_data_o stable until the output handshake completes.
REQ-021 out_data_o SHALL hold its last value outside DONE; only out_valid_o qualifies it.
REQ-022 Beats presented while in DONE SHALL be ignored and SHALL not alter any state.

Reset
REQ-023 While fcl_rst is 1 at a clock edge: state=IDLE, counter=0, all accumulators=0, out_data_o=0, out_valid_o=0; in_ready_o SHALL be 1 from the first edge after reset deasserts.
REQ-024 A reset asserted mid-frame or in DONE SHALL discard the partial or pending result without producing an output handshake.

Configuration
REQ-025 With FCL_SAT_EN defined, each add SHALL saturate to the signed ACC_WIDTH limits (0x200000 / 0x1FFFFF for 22 bits); without it, adds SHALL wrap modulo 2^ACC_WIDTH in two's complement.

Structure
REQ-026 Package fcl_pkg SHALL hold the default width constants, the FSM state enum typedef and the saturating-add function used under FCL_SAT_EN.
REQ-027 One sub-module, fcl_mac_lane (multiply, sign-extend, bias load, accumulate, optional saturate), SHALL be instantiated NUM_NEURONS times; the FSM and counter SHALL live in fcl_mac_accum.

Verification
REQ-028 NUM_TERMS=3, bias={0,0,0,0}, data 1,2,3, weights all 1 -> out_valid_o 1 cycle after beat 3, every lane = 6.
REQ-029 NUM_TERMS=2, lane0 bias=-10, data 3,-4, weights 5,5 -> lane0 = -15 (0x3FFFF1).
REQ-030 FCL_SAT_EN, bias=0x1FFF00, data 127, weight 127, NUM_TERMS=2 -> 0x1FFFFF; same without the macro -> 0x203E02 (wrapped).
REQ-031 out_ready_i held 0 for 5 cycles with in_valid_i held 1 -> out_data_o stable, in_ready_o 0, no beats consumed; release -> IDLE, next frame correct.
REQ-032 fcl_rst pulsed after 2 of 3 beats -> no out_valid_o; a following full frame returns only that frame's sum.
REQ-033 NUM_TERMS=1, bias=7, data 2, weight -3 -> out_valid_o next cycle, lane = 1.
